// File: rtl/ahb_req_master.sv
// AHB-Lite master that runs one queued request as SINGLE/INCR transfers with
// pipelined address/data phases and returns read data plus sticky error status.
module ahb_req_master #(
  parameter int MAX_BEATS = 8,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [29:0]       req_addr,
  input  logic [3:0]        req_byte_sel,
  input  logic [3:0]        req_len,
  input  logic [255:0]      req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [255:0]      rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [3:0]        hwstrb,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  state_t         state_r;
  logic [31:0]    base_r;
  logic [255:0]   wdata_r;
  logic [3:0]     beats_r;
  logic [3:0]     addr_idx_r;   // number of address phases driven so far
  logic [2:0]     data_idx_r;
  logic           data_act_r;

  logic [3:0]     beats_s;
  logic [31:0]    nxt_addr_s;
  logic [2:0]     addr_beat_s;
  logic           last_issued_s;
  logic [1:0]     nxt_trans_s;

  assign hsize         = 3'b010;
  assign nxt_addr_s    = base_r + {26'd0, addr_idx_r, 2'b00};
  assign addr_beat_s   = addr_idx_r[2:0] - 3'd1;
  assign last_issued_s = (addr_idx_r >= beats_r);

  // Clamp the requested length into 1..MAX_BEATS.
  always_comb begin
    if (req_len == 4'd0) begin
      beats_s = 4'd1;
    end else if (req_len > 4'(MAX_BEATS)) begin
      beats_s = 4'(MAX_BEATS);
    end else begin
      beats_s = req_len;
    end
  end

  // A beat landing on a 1KB boundary restarts the burst with NONSEQ.
  always_comb begin
    if (nxt_addr_s[9:0] == 10'd0) begin
      nxt_trans_s = HT_NONSEQ;
    end else begin
      nxt_trans_s = HT_SEQ;
    end
  end

  // Request/transfer/response sequencer with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 256'd0;
      rsp_err    <= 1'b0;
      haddr      <= 32'd0;
      htrans     <= HT_IDLE;
      hwrite     <= 1'b0;
      hburst     <= 3'b000;
      hwstrb     <= 4'd0;
      hwdata     <= '0;
      base_r     <= 32'd0;
      wdata_r    <= 256'd0;
      beats_r    <= 4'd0;
      addr_idx_r <= 4'd0;
      data_idx_r <= 3'd0;
      data_act_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            base_r     <= {req_addr, 2'b00};
            wdata_r    <= req_wdata;
            beats_r    <= beats_s;
            addr_idx_r <= 4'd1;
            data_act_r <= 1'b0;
            rsp_rdata  <= 256'd0;
            rsp_err    <= 1'b0;
            haddr      <= {req_addr, 2'b00};
            htrans     <= HT_NONSEQ;
            hwrite     <= req_write;
            hburst     <= (beats_s == 4'd1) ? 3'b000 : 3'b001;
            hwstrb     <= req_byte_sel;
            state_r    <= S_XFER;
          end
        end
        S_XFER: begin
          if (data_act_r && hresp) begin
            // Two-cycle ERROR: cancel the pending address now, finish on the second cycle.
            rsp_err <= 1'b1;
            htrans  <= HT_IDLE;
            if (hready) begin
              data_act_r <= 1'b0;
              rsp_valid  <= 1'b1;
              state_r    <= S_RESP;
            end
          end else if (hready) begin
            if (data_act_r && !hwrite) begin
              rsp_rdata[DATA_W*data_idx_r +: DATA_W] <= hrdata;
            end
            if (htrans != HT_IDLE) begin
              data_act_r <= 1'b1;
              data_idx_r <= addr_beat_s;
              hwdata     <= hwrite ? wdata_r[DATA_W*addr_beat_s +: DATA_W] : '0;
              if (!last_issued_s) begin
                haddr      <= nxt_addr_s;
                htrans     <= nxt_trans_s;
                addr_idx_r <= addr_idx_r + 4'd1;
              end else begin
                htrans <= HT_IDLE;
              end
            end else begin
              data_act_r <= 1'b0;
              rsp_valid  <= 1'b1;
              state_r    <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_r   <= S_IDLE;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          htrans    <= HT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_req_master.sv
// Self-checking bench for ahb_req_master: directed scenarios plus randomized
// requests, with a bench-side AHB slave and a reference model of expected beats.
module tb_ahb_req_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_write;
  logic [29:0]  req_addr;
  logic [3:0]   req_byte_sel, req_len;
  logic [255:0] req_wdata;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [255:0] rsp_rdata;
  logic [31:0]  haddr, hwdata, hrdata;
  logic [1:0]   htrans;
  logic         hwrite, hready, hresp;
  logic [2:0]   hsize, hburst;
  logic [3:0]   hwstrb;

  always #5 clk = ~clk;

  ahb_req_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_byte_sel(req_byte_sel), .req_len(req_len),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwstrb(hwstrb), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  int           checks = 0;
  int           errors = 0;
  logic [31:0]  rd_mem [8];
  logic [255:0] wd;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 8; i++) begin
      rd_mem[i]         = $urandom;
      wd[32*i +: 32]    = $urandom;
    end
  endtask

  // Entered just after a negedge with the DUT idle; returns after the response handshake.
  task automatic run_req(input logic wr, input logic [29:0] addr, input logic [3:0] len,
                         input logic [3:0] strb, input int wmode, input int err_beat,
                         input bit chk_lat);
    int beats, n_acc, dp_beat, stall, k, good, hold, exp_acc;
    bit dp_act, err_stage, is_err;
    logic [31:0]  base, a;
    logic [255:0] exp_rd;
    beats  = (len == 4'd0) ? 1 : ((len > 4'd8) ? 8 : int'(len));
    is_err = (err_beat < beats);
    base   = {addr, 2'b00};
    req_write = wr; req_addr = addr; req_len = len; req_byte_sel = strb; req_wdata = wd;
    req_valid = 1'b1;
    chk("req_ready_idle", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    dp_act = 0; err_stage = 0; n_acc = 0; dp_beat = 0; stall = 0; k = 1;
    while (!rsp_valid && k < 200) begin
      hresp = 1'b0; hready = 1'b1; hrdata = $urandom;
      if (dp_act) begin
        if (!wr) hrdata = rd_mem[dp_beat];
        if (dp_beat == err_beat) begin
          if (!err_stage) begin
            hresp = 1'b1; hready = 1'b0; err_stage = 1;
          end else begin
            chk("err_htrans_idle", htrans, 2'b00);
            hresp = 1'b1; hready = 1'b1;
          end
        end else if (stall > 0) begin
          hready = 1'b0; stall--;
        end
      end
      if (dp_act && hready) begin
        if (wr && !hresp) chk("hwdata", hwdata, wd[32*dp_beat +: 32]);
        dp_act = 0;
      end
      if (htrans != 2'b00 && hready && !hresp) begin
        a = base + 32'(4 * n_acc);
        chk("haddr", haddr, a);
        chk("htrans", htrans, (n_acc == 0 || a[9:0] == 10'd0) ? 2'b10 : 2'b11);
        chk("hwrite", hwrite, wr);
        chk("hburst", hburst, (beats == 1) ? 3'b000 : 3'b001);
        chk("hwstrb", hwstrb, strb);
        chk("hsize", hsize, 3'b010);
        dp_act = 1; dp_beat = n_acc; n_acc++;
        if (wmode == 2 && dp_beat == 2) stall = 2;
        else if (wmode == 1 && $urandom_range(0, 3) == 0) stall = $urandom_range(1, 3);
        else stall = 0;
      end
      @(negedge clk);
      k++;
    end
    hready = 1'b1; hresp = 1'b0;
    chk("rsp_valid", rsp_valid, 1'b1);
    exp_acc = is_err ? err_beat + 1 : beats;
    chk("beats_issued", n_acc, exp_acc);
    if (chk_lat) chk("latency", k, beats + 2);
    good   = is_err ? err_beat : beats;
    exp_rd = 256'd0;
    for (int i = 0; i < good; i++) if (!wr) exp_rd[32*i +: 32] = rd_mem[i];
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", rsp_err, is_err);
    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold_valid", rsp_valid, 1'b1);
      chk("rsp_hold_rdata", rsp_rdata, exp_rd);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_cleared", rsp_valid, 1'b0);
    chk("req_ready_back", req_ready, 1'b1);
    chk("htrans_idle_after", htrans, 2'b00);
  endtask

  initial begin
    logic [31:0] r;
    int eb;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 30'd0; req_len = 4'd0;
    req_byte_sel = 4'd0; req_wdata = 256'd0; rsp_ready = 1'b0;
    hrdata = 32'd0; hready = 1'b1; hresp = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwrite", hwrite, 1'b0);
    chk("rst_hburst", hburst, 3'b000);
    chk("rst_hwstrb", hwstrb, 4'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 256'd0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_hsize", hsize, 3'b010);

    // Read len=1 at byte 0x400, zero wait.
    fill_rand(); rd_mem[0] = 32'hA5A5A5A5;
    run_req(1'b0, 30'h100, 4'd1, 4'hF, 0, 99, 1'b1);
    chk("single_read_word", rsp_rdata[31:0], 32'hA5A5A5A5);
    // Write len=8 at byte 0x100, zero wait.
    fill_rand();
    run_req(1'b1, 30'h40, 4'd8, 4'hF, 0, 99, 1'b1);
    // Write len=4 with two wait states on beat 2.
    fill_rand();
    run_req(1'b1, 30'h123, 4'd4, 4'h5, 2, 99, 1'b0);
    // Read len=4 from byte 0x3F8 crossing the 1KB boundary.
    fill_rand();
    run_req(1'b0, 30'hFE, 4'd4, 4'hF, 0, 99, 1'b1);
    // Read len=6 with ERROR on beat 2.
    fill_rand();
    run_req(1'b0, 30'h200, 4'd6, 4'hF, 0, 2, 1'b0);
    // Over-long length clamps to 8 beats.
    fill_rand();
    run_req(1'b0, 30'h3FFFFFFC, 4'd15, 4'h3, 0, 99, 1'b1);

    for (int it = 0; it < 30; it++) begin
      fill_rand();
      r = $urandom;
      case ($urandom_range(0, 2))
        0:       req_addr = r[29:0];
        1:       req_addr = {r[29:8], 8'(250 + $urandom_range(0, 5))};
        default: req_addr = 30'h3FFFFFFA + 30'($urandom_range(0, 5));
      endcase
      eb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 99;
      run_req(1'($urandom_range(0, 1)), req_addr, 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 1, eb, 1'b0);
    end

    // Reset in the middle of a burst, then a len=0 request.
    fill_rand();
    req_write = 1'b1; req_addr = 30'h80; req_len = 4'd8; req_byte_sel = 4'hF; req_wdata = wd;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_htrans", htrans, 2'b00);
    chk("midrst_haddr", haddr, 32'd0);
    chk("midrst_hburst", hburst, 3'b000);
    chk("midrst_hwdata", hwdata, 32'd0);
    chk("midrst_hwrite", hwrite, 1'b0);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_no_rsp", rsp_valid, 1'b0);
    fill_rand();
    run_req(1'b0, 30'h155, 4'd0, 4'hF, 0, 99, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
